// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the 16-bit multi-cycle shift/rotate sequencer.
// Optional zero-bubble back-to-back issue is enabled with SHIFT_SEQ_B2B_EN (see shift_sequencer).
package shift_seq_pkg;

    localparam int N        = 16;
    localparam int CW       = 6;
    localparam int SW       = 4;
    localparam int STEP_MAX = 15;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRA = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Largest step the single shift stage can apply this cycle.
    function automatic logic [SW-1:0] step_of(input logic [CW-1:0] rem);
        if (rem > CW'(STEP_MAX)) begin
            return SW'(STEP_MAX);
        end
        return rem[SW-1:0];
    endfunction

endpackage

// File: rtl/shift_sequencer_stage.sv
// Combinational single-step shifter: 16-bit data, 0..15 positions, ROL/SLL/ROR/SRA.
module shift_stage
    import shift_seq_pkg::*;
(
    input  logic [N-1:0]  data_i,
    input  op_e           op_i,
    input  logic [SW-1:0] cnt_i,
    output logic [N-1:0]  data_o
);

    logic [4:0]          inv_cnt;
    logic signed [N-1:0] data_s;

    // For cnt_i == 0 the complementary shift is by 16, which yields zero.
    assign inv_cnt = 5'd16 - {1'b0, cnt_i};
    assign data_s  = data_i;

    always_comb begin
        data_o = data_i;
        case (op_i)
            OP_ROL:  data_o = (data_i << cnt_i) | (data_i >> inv_cnt);
            OP_SLL:  data_o = data_i << cnt_i;
            OP_ROR:  data_o = (data_i >> cnt_i) | (data_i << inv_cnt);
            OP_SRA:  data_o = $unsigned(data_s >>> cnt_i);
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: applies a 0..63 count as steps of at most 15.
// Define SHIFT_SEQ_B2B_EN to accept a new request in the DONE handshake cycle (zero bubble).
module shift_sequencer
    import shift_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [CW-1:0] in_cnt,
    input  logic [1:0]    in_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          busy,
    output state_e        dbg_state
);

    state_e        state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic [CW-1:0] rem_q, rem_d;
    op_e           op_q, op_d;

    logic [SW-1:0] step;
    logic [N-1:0]  stage_out;

    assign step      = step_of(rem_q);
    assign dbg_state = state_q;

    shift_stage u_stage (
        .data_i (data_q),
        .op_i   (op_q),
        .cnt_i  (step),
        .data_o (stage_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            op_q    <= OP_ROL;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        rem_d     = rem_q;
        op_d      = op_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    op_d    = op_e'(in_op);
                    rem_d   = in_cnt;
                    state_d = (in_cnt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy   = 1'b1;
                data_d = stage_out;
                rem_d  = rem_q - {{(CW-SW){1'b0}}, step};
                if (rem_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = data_q;
                if (out_ready) begin
                    state_d = ST_IDLE;
`ifdef SHIFT_SEQ_B2B_EN
                    // Result leaves and the next request enters on the same edge.
                    in_ready = 1'b1;
                    if (in_valid) begin
                        data_d  = in_data;
                        op_d    = op_e'(in_op);
                        rem_d   = in_cnt;
                        state_d = (in_cnt == '0) ? ST_DONE : ST_SHIFT;
                    end
`else
                    in_ready = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
